// File: rtl/polyphase_tx_interp_if.sv
// -----------------------------------------------------------------------------
// polyphase_tx_interp_if
// Bus bundle for the transmit polyphase interpolator.
//   sym_clk_en  symbol strobe (one clk wide, aligned with every OSR-th sample)
//   sam_clk_en  sample strobe (one clk wide)
//   sym_in      signed 1s17 symbol
//   coef_wr_en  coefficient write strobe
//   coef_addr   coefficient index 0..COEFF_LEN-1
//   coef_data   signed 1s17 coefficient
//   y           signed 1s17 filtered sample, held between sample strobes
//   phase       polyphase index of the sample being computed
// master drives strobes, symbols and coefficients; slave is the filter.
// -----------------------------------------------------------------------------
interface polyphase_tx_interp_if;
  logic        sym_clk_en;
  logic        sam_clk_en;
  logic [17:0] sym_in;
  logic        coef_wr_en;
  logic [6:0]  coef_addr;
  logic [17:0] coef_data;
  logic [17:0] y;
  logic [1:0]  phase;

  modport master (
    output sym_clk_en, sam_clk_en, sym_in, coef_wr_en, coef_addr, coef_data,
    input  y, phase
  );

  modport slave (
    input  sym_clk_en, sam_clk_en, sym_in, coef_wr_en, coef_addr, coef_data,
    output y, phase
  );
endinterface

// File: rtl/polyphase_tx_interp.sv
// -----------------------------------------------------------------------------
// polyphase_tx_interp
// Transmit pulse-shaping interpolator: one symbol in per sym_clk_en, OSR
// filtered samples out, one per sam_clk_en. Each sample is the dot product of
// the symbol delay line with one polyphase branch of the prototype filter,
// computed over the OSR clk cycles of a sample period by NUM_MAC shared MACs.
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    polyphase_tx_interp_if.slave (strobes, symbol, coefficient write
//          port, y output, phase output)
//
// Build option
//   POLY_TX_ROUND_EN  when defined the output is rounded half-up; otherwise it
//                     is truncated toward negative infinity. Saturation is the
//                     same in both builds.
//
// Timing: the sample for the line/phase state present after sample strobe
// E_n is accumulated during period n, parked in r_sum at E_{n+1}, and reduced
// onto y at E_{n+2}.
// -----------------------------------------------------------------------------
module polyphase_tx_interp #(
  parameter int COEFF_LEN = 81,
  parameter int OSR       = 4,
  parameter int PHASE_LEN = 21,
  parameter int NUM_MAC   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  polyphase_tx_interp_if.slave  bus
);

  localparam int DW     = 18;                        // 1s17 data width
  localparam int FRAC   = 17;                        // fraction bits of 1s17
  localparam int PROD_W = 2 * DW;                    // 2s34 product
  localparam int ACC_W  = PROD_W + 5;                // 5 guard bits
  localparam int RND_W  = ACC_W + 1;                 // headroom for rounding add
  localparam int PH_W   = $clog2(OSR);
  localparam int TAP_W  = $clog2(NUM_MAC * OSR + 1);
  localparam int IDX_W  = 8;

  localparam logic [TAP_W-1:0] PHASE_LEN_T = TAP_W'(PHASE_LEN);
  localparam logic [IDX_W-1:0] COEFF_LEN_T = IDX_W'(COEFF_LEN);
  localparam logic [6:0]       COEFF_ADDR_LIM = 7'(COEFF_LEN);
  localparam logic [PH_W-1:0]  LAST_SLOT   = PH_W'(OSR - 1);

`ifdef POLY_TX_ROUND_EN
  localparam logic signed [RND_W-1:0] ROUND_ADD = RND_W'(1) <<< (FRAC - 1);
`else
  localparam logic signed [RND_W-1:0] ROUND_ADD = '0;
`endif

  // Full-scale limits in 2s34: sums at or above +1.0, or below -1.0, clip.
  localparam logic signed [RND_W-1:0] SAT_HI = RND_W'(1) <<< (2 * FRAC);
  localparam logic signed [RND_W-1:0] SAT_LO = -SAT_HI;

  // State
  logic signed [DW-1:0]    r_line [PHASE_LEN];
  logic signed [DW-1:0]    r_coef [COEFF_LEN];
  logic [PH_W-1:0]         r_phase;
  logic [PH_W-1:0]         r_cnt;
  logic                    r_slots_done;   // late period: last slot already added
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_sum;          // completed sample awaiting reduction
  logic [DW-1:0]           r_y;

  // Datapath
  logic signed [PROD_W-1:0] w_prod [NUM_MAC];
  logic signed [ACC_W-1:0]  w_slot_sum;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [RND_W-1:0]  w_round;
  logic [DW-1:0]            w_y_next;
  logic                     w_slot_en;

  assign w_slot_en = !r_slots_done;

  // ---------------------------------------------------------------------------
  // Symbol delay line, phase and coefficient RAM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
      for (int k = 0; k < PHASE_LEN; k++) r_line[k] <= '0;
      // NOTE: the coefficient store is a register array with an explicit
      // reset, so a reset leaves an all-zero filter rather than stale taps.
      for (int i = 0; i < COEFF_LEN; i++) r_coef[i] <= '0;
    end else begin
      if (bus.sym_clk_en) begin
        r_line[0] <= bus.sym_in;
        for (int k = 1; k < PHASE_LEN; k++) r_line[k] <= r_line[k-1];
      end

      // A symbol edge always restarts the branch sequence at phase 0.
      if (bus.sym_clk_en)
        r_phase <= '0;
      else if (bus.sam_clk_en)
        r_phase <= (r_phase == LAST_SLOT) ? '0 : r_phase + 1'b1;

      // Reads are combinational from the registers, so a same-cycle write
      // is only visible from the next slot onward.
      if (bus.coef_wr_en && (bus.coef_addr < COEFF_ADDR_LIM))
        r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared MACs: in slot c, MAC j handles tap k = j*OSR + c of branch r_phase,
  // i.e. coefficient h[r_phase + OSR*k]. Out-of-range taps contribute 0.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < NUM_MAC; j++) begin : g_mac
    logic [TAP_W-1:0]         w_tap;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_use;
    logic signed [PROD_W-1:0] w_mul;

    assign w_tap = TAP_W'(j * OSR) + TAP_W'(r_cnt);
    assign w_idx = IDX_W'(r_phase) + IDX_W'(w_tap) * IDX_W'(OSR);
    assign w_use = w_slot_en && (w_tap < PHASE_LEN_T) && (w_idx < COEFF_LEN_T);
    // Operands widened first so the multiply is carried out at product width.
    assign w_mul = PROD_W'(r_line[w_tap]) * PROD_W'(r_coef[w_idx[6:0]]);
    assign w_prod[j] = w_use ? w_mul : '0;
  end

  // NOTE: combinational blocks assign a default before any conditional or
  // loop update so no path leaves a variable unassigned (no latch).
  always_comb begin
    w_slot_sum = '0;
    for (int j = 0; j < NUM_MAC; j++)
      w_slot_sum = w_slot_sum + ACC_W'(w_prod[j]);
  end

  assign w_acc_next = r_acc + w_slot_sum;

  // ---------------------------------------------------------------------------
  // Slot counter and accumulator. The counter restarts after every sample
  // strobe and parks on the last slot; r_slots_done stops a long period from
  // adding that slot more than once. A short period simply never reaches the
  // later slots.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_slots_done <= 1'b0;
      r_acc        <= '0;
      r_sum        <= '0;
      r_y          <= '0;
    end else if (bus.sam_clk_en) begin
      r_cnt        <= '0;
      r_slots_done <= 1'b0;
      r_acc        <= '0;
      r_sum        <= w_acc_next;   // includes the slot ending on this edge
      r_y          <= w_y_next;     // sample completed one period ago
    end else begin
      r_acc <= w_acc_next;
      if (r_cnt == LAST_SLOT)
        r_slots_done <= 1'b1;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reduction of the 2s34 sum to 1s17: optional half-LSB add, then bit select
  // [34:17] with clipping to the 1s17 range.
  // ---------------------------------------------------------------------------
  assign w_round = RND_W'(r_sum) + ROUND_ADD;

  always_comb begin
    w_y_next = w_round[2*FRAC:FRAC];
    if (w_round >= SAT_HI)
      w_y_next = 18'h1FFFF;
    else if (w_round < SAT_LO)
      w_y_next = 18'h20000;
  end

  assign bus.y     = r_y;
  assign bus.phase = r_phase;

endmodule

// File: doc/polyphase_tx_interp.md
Name: polyphase_tx_interp

Overview:
Transmit-side pulse-shaping interpolator for the symbol-to-sample path. It accepts one symbol per sym_clk_en and emits OSR filtered samples per symbol, one per sam_clk_en. The polyphase FIR shares a small bank of MACs across the clk cycles within each sample period. It is the transmit-end counterpart of the sample-rate time-shared receive filter, and is driven by the same clk / sam_clk_en / sym_clk_en enables.

Parameters:
COEFF_LEN, 81, total prototype filter taps.
OSR, 4, samples per symbol; also the number of clk cycles per sample period.
PHASE_LEN, 21, taps per polyphase branch (ceil(COEFF_LEN/OSR)).
NUM_MAC, 6, parallel MACs; NUM_MAC*OSR must be >= PHASE_LEN.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
sym_clk_en  in  1  symbol strobe; one clk wide; coincides with every OSR-th sam_clk_en.
sam_clk_en  in  1  sample strobe; one clk wide; nominally every OSR clks.
sym_in  in  18  signed symbol value, format 1s17.
coef_wr_en  in  1  coefficient write strobe.
coef_addr  in  7  coefficient index, 0..COEFF_LEN-1.
coef_data  in  18  signed coefficient, format 1s17.
y  out  18  signed filtered sample, format 1s17; held between sam_clk_en.
phase  out  2  polyphase index of the sample currently being computed.

Behaviour:
- Reset (async): symbol delay line, coefficient RAM, accumulators, pipeline, y, phase and the cycle counter all clear to 0. Reset mid-operation discards all in-flight sums.
- Symbol delay line s[0..PHASE_LEN-1]:
  - On a sym_clk_en edge, s[0] <= sym_in and s[k] <= s[k-1].
  - Otherwise the line holds.
- Phase:
  - On a sam_clk_en edge, phase increments mod OSR.
  - If sym_clk_en is also high, phase is forced to 0 instead.
  - A sym_clk_en without sam_clk_en still shifts the line and zeroes phase.
- Sample computation: for the phase p and line state present after sam_clk_en edge E_n, the block forms sum over k=0..PHASE_LEN-1 of s[k]*h[p+OSR*k].
  - A term whose index p+OSR*k >= COEFF_LEN contributes 0. With the defaults, phase 0 has 21 taps and phases 1..3 have 20.
- Time sharing:
  - A cycle counter c runs 0..OSR-1 and restarts at 0 on the clk after each sam_clk_en.
  - In slot c, MAC j handles tap k = j*OSR + c. Slots with k >= PHASE_LEN contribute 0.
  - If sam_clk_en arrives early (period < OSR), unprocessed slots contribute 0.
  - If the period is late (> OSR), c saturates at OSR-1 and no slot is accumulated twice.
- Arithmetic:
  - Products are 1s17 x 1s17 = 2s34 (36 bit).
  - Accumulation is full precision, 41 bit (5 guard bits).
  - Final sum is reduced to 1s17 by taking bits [34:17] with saturation: above +1-2^-17 gives 0x1FFFF; below -1 gives 0x20000.
- Latency: y updates only on sam_clk_en edges. The sample for the state at E_n appears on y at edge E_{n+2} (two sample periods), then holds.
- Coefficient writes:
  - coef_wr_en writes coef_data to h[coef_addr] at the next clk edge.
  - coef_addr >= COEFF_LEN is ignored.
  - A write during a sample period may affect that sample; a write issued a full period before E_n is guaranteed used for E_n.
  - Simultaneous write and read of the same index returns the old value for that slot.

Optional Feature:
POLY_TX_ROUND_EN: when defined, the block adds 2^16 LSBs (half an output LSB) to the final sum before bit selection and saturation (round-half-up). When undefined, it truncates toward negative infinity. Saturation behaviour is identical in both builds.

Test Plan:
- Reset: assert reset mid-stream -> y=0x00000 and phase=0 asynchronously; after release, output stays 0 until coefficients are loaded.
- Impulse: h[0]=0x1FFFF, all others 0; one symbol 0x10000 then zeros -> y=0x0FFFF (truncate) exactly 2 sample periods after the symbol edge, y=0 for phases 1..3, then 0.
- Flat filter: h[0..80]=0x08000 (0.25), constant symbols 0x01000 (1/32) -> steady state phase 0 y=0x05400 (21 taps), phases 1..3 y=0x05000 (20 taps).
- Saturation: h all 0x1FFFF, symbols all 0x20000 (-1) -> y=0x20000; symbols all 0x1FFFF -> y=0x1FFFF.
- Rounding: h[0]=0x00001, symbol 0x10000 -> y=0x00001 with POLY_TX_ROUND_EN, y=0x00000 without.
- Boundaries: write coef_addr=81 with 0x1FFFF -> no output change. sam_clk_en every 3 clks -> sample equals the slot 0..2 partial sum. sym_clk_en alone -> phase=0 and line shifted.
